// File: rtl/sim_memory_access_bridge.sv
// Core-side load/store to 64-bit-line memory model bridge with an in-order read tag FIFO.
// Optional SIM_MEM_BRIDGE_ALIGN_CHECK_EN: drop misaligned requests and pulse oALIGN_ERR instead of aligning down.
module sim_memory_access_bridge #(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
`ifdef SIM_MEM_BRIDGE_ALIGN_CHECK_EN
  output logic        oALIGN_ERR,
`endif
  input  logic        iREQ_VALID,
  output logic        oREQ_BUSY,
  input  logic [1:0]  iREQ_ORDER,
  input  logic        iREQ_RW,
  input  logic [31:0] iREQ_ADDR,
  input  logic [31:0] iREQ_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic        oMEM_RW,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  output logic        oMEM_LOCK,
  input  logic [63:0] iMEM_DATA,
  output logic        oRD_VALID,
  input  logic        iRD_BUSY,
  output logic [31:0] oRD_DATA
);

  localparam logic [P_TAG_DEPTH_N+1:0] LP_DEPTH = P_TAG_DEPTH[P_TAG_DEPTH_N+1:0];

  logic                     iss_vld_q, iss_vld_d;
  logic [1:0]               iss_order_q, iss_order_d;
  logic [3:0]               iss_mask_q, iss_mask_d;
  logic                     iss_rw_q, iss_rw_d;
  logic [31:0]              iss_addr_q, iss_addr_d;
  logic [31:0]              iss_data_q, iss_data_d;
  logic [2:0]               iss_boff_q, iss_boff_d;
  logic [4:0]               tag_mem_q [P_TAG_DEPTH];
  logic [P_TAG_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [P_TAG_DEPTH_N:0]   cnt_q, cnt_d;
  logic                     rsp_vld_q, rsp_vld_d;
  logic [31:0]              rsp_data_q, rsp_data_d;

  logic                     accept, fwd, drain, push, pop;
  logic [31:0]              addr_al, wdata, rd_word, rd_shift, rd_data;
  logic [3:0]               mask;
  logic [4:0]               tag;
  logic [P_TAG_DEPTH_N+1:0] occ;

  assign oMEM_LOCK = rsp_vld_q && iRD_BUSY;
  assign pop       = iMEM_VALID && !oMEM_LOCK && (cnt_q != '0);
  assign drain     = iss_vld_q && !iMEM_LOCK;
  assign push      = drain && !iss_rw_q;

  // A read still sitting in the issue register already owns a tag slot,
  // otherwise a read accepted behind it could overflow the FIFO.
  assign occ = {1'b0, cnt_q}
             + {{(P_TAG_DEPTH_N+1){1'b0}}, iss_vld_q && !iss_rw_q}
             - {{(P_TAG_DEPTH_N+1){1'b0}}, pop};
  assign oREQ_BUSY = (iss_vld_q && iMEM_LOCK) || (occ >= LP_DEPTH);
  assign accept    = iREQ_VALID && !oREQ_BUSY;

`ifdef SIM_MEM_BRIDGE_ALIGN_CHECK_EN
  logic misalign, align_err_q;
  assign misalign   = ((iREQ_ORDER == 2'b01) && iREQ_ADDR[0])
                   || (iREQ_ORDER[1] && (iREQ_ADDR[1:0] != 2'b00));
  assign fwd        = accept && !misalign;
  assign oALIGN_ERR = align_err_q;
`else
  assign fwd = accept;
`endif

  always_comb begin
    addr_al = iREQ_ADDR;
    mask    = 4'b1111;
    wdata   = iREQ_DATA;
    case (iREQ_ORDER)
      2'b00: begin
        mask  = 4'b0001 << iREQ_ADDR[1:0];
        wdata = {4{iREQ_DATA[7:0]}};
      end
      2'b01: begin
        addr_al[0] = 1'b0;
        mask       = 4'b0011 << {iREQ_ADDR[1], 1'b0};
        wdata      = {2{iREQ_DATA[15:0]}};
      end
      default: addr_al[1:0] = 2'b00;
    endcase
  end

  always_comb begin
    tag      = tag_mem_q[rd_ptr_q];
    rd_word  = tag[4] ? iMEM_DATA[63:32] : iMEM_DATA[31:0];
    rd_shift = rd_word >> {tag[3:2], 3'b000};
    case (tag[1:0])
      2'b00:   rd_data = {24'h0, rd_shift[7:0]};
      2'b01:   rd_data = {16'h0, rd_shift[15:0]};
      default: rd_data = rd_shift;
    endcase
  end

  always_comb begin
    iss_vld_d   = iss_vld_q && !drain;
    iss_order_d = iss_order_q;
    iss_mask_d  = iss_mask_q;
    iss_rw_d    = iss_rw_q;
    iss_addr_d  = iss_addr_q;
    iss_data_d  = iss_data_q;
    iss_boff_d  = iss_boff_q;
    if (fwd) begin
      iss_vld_d   = 1'b1;
      iss_order_d = iREQ_ORDER;
      iss_mask_d  = mask;
      iss_rw_d    = iREQ_RW;
      iss_addr_d  = {addr_al[31:2], 2'b00};
      iss_data_d  = wdata;
      iss_boff_d  = addr_al[2:0];
    end
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + {{P_TAG_DEPTH_N{1'b0}}, push} - {{P_TAG_DEPTH_N{1'b0}}, pop};
    rsp_vld_d  = rsp_vld_q && iRD_BUSY;
    rsp_data_d = rsp_data_q;
    if (pop) begin
      rsp_vld_d  = 1'b1;
      rsp_data_d = rd_data;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push) tag_mem_q[wr_ptr_q] <= {iss_boff_q, iss_order_q};
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      iss_vld_q   <= 1'b0;
      iss_order_q <= 2'b00;
      iss_mask_q  <= 4'h0;
      iss_rw_q    <= 1'b0;
      iss_addr_q  <= 32'h0;
      iss_data_q  <= 32'h0;
      iss_boff_q  <= 3'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
`ifdef SIM_MEM_BRIDGE_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      iss_vld_q   <= iss_vld_d;
      iss_order_q <= iss_order_d;
      iss_mask_q  <= iss_mask_d;
      iss_rw_q    <= iss_rw_d;
      iss_addr_q  <= iss_addr_d;
      iss_data_q  <= iss_data_d;
      iss_boff_q  <= iss_boff_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SIM_MEM_BRIDGE_ALIGN_CHECK_EN
      align_err_q <= accept && misalign;
`endif
`ifndef SYNTHESIS
      if (iMEM_VALID && !oMEM_LOCK && (cnt_q == '0))
        $display("[ERROR] sim_memory_access_bridge: returned line with no outstanding read, dropped");
`ifdef SIM_MEM_BRIDGE_ALIGN_CHECK_EN
      if (accept && misalign)
        $display("[ERROR] sim_memory_access_bridge: misaligned request addr=%08h order=%0d",
                 iREQ_ADDR, iREQ_ORDER);
`endif
`endif
    end
  end

  assign oMEM_REQ   = iss_vld_q;
  assign oMEM_ORDER = iss_order_q;
  assign oMEM_MASK  = iss_mask_q;
  assign oMEM_RW    = iss_rw_q;
  assign oMEM_ADDR  = iss_addr_q;
  assign oMEM_DATA  = iss_data_q;
  assign oRD_VALID  = rsp_vld_q;
  assign oRD_DATA   = rsp_data_q;

endmodule
